// File: rtl/cnn_bn_param_sequencer.sv
// Layer controller for the batch-norm datapath: loads per-channel weight/bias pairs, then streams
// channel-major pixels with matching params. Optional stall counter behind BN_SEQ_PERF_CNT_EN.
module cnn_bn_param_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CH     = 256,
    parameter int CH_W       = 8,
    parameter int PIX_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [CH_W:0]         cfg_num_ch,
    input  logic [PIX_W-1:0]      cfg_pix_per_ch,
    input  logic                  prm_valid,
    output logic                  prm_ready,
    input  logic [DATA_WIDTH-1:0] prm_weight,
    input  logic [DATA_WIDTH-1:0] prm_bias,
    input  logic                  pxl_valid_in,
    output logic                  pxl_ready,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  bn_valid,
    output logic [DATA_WIDTH-1:0] bn_pxl,
    output logic                  bn_weight_valid,
    output logic [DATA_WIDTH-1:0] bn_weight,
    output logic                  bn_bias_valid,
    output logic [DATA_WIDTH-1:0] bn_bias,
    output logic [CH_W-1:0]       ch_idx,
    output logic                  busy,
`ifdef BN_SEQ_PERF_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q;
    logic [CH_W:0]         numCh_q;
    logic [PIX_W-1:0]      pixPerCh_q;
    logic [CH_W-1:0]       wrPtr_q;
    logic [CH_W-1:0]       ch_q;
    logic [PIX_W-1:0]      pixCnt_q;
    logic                  bnValid_q;
    logic [DATA_WIDTH-1:0] bnPxl_q;
    logic [DATA_WIDTH-1:0] bnWeight_q;
    logic [DATA_WIDTH-1:0] bnBias_q;
    logic                  done_q;
`ifdef BN_SEQ_PERF_CNT_EN
    logic [31:0]           stallCnt_q;
`endif

    logic [DATA_WIDTH-1:0] weightTab_q [MAX_CH];
    logic [DATA_WIDTH-1:0] biasTab_q   [MAX_CH];

    logic lastLoad;
    logic lastPix;
    logic lastCh;
    logic pxlAccept;

    assign lastLoad  = ({1'b0, wrPtr_q} == (numCh_q - (CH_W+1)'(1)));
    assign lastPix   = (pixCnt_q == (pixPerCh_q - PIX_W'(1)));
    assign lastCh    = ({1'b0, ch_q} == (numCh_q - (CH_W+1)'(1)));
    assign pxlAccept = (state_q == RUN) && pxl_valid_in;

    // Parameter table is deliberately not reset; every layer reloads it before use.
    always_ff @(posedge clk) begin
        if ((state_q == LOAD) && prm_valid) begin
            weightTab_q[wrPtr_q] <= prm_weight;
            biasTab_q[wrPtr_q]   <= prm_bias;
        end
    end

    // Layer FSM with counters and registered BN outputs; done is raised on the edge entering DONE
    // so it coincides with the final BN beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            numCh_q    <= '0;
            pixPerCh_q <= '0;
            wrPtr_q    <= '0;
            ch_q       <= '0;
            pixCnt_q   <= '0;
            bnValid_q  <= 1'b0;
            bnPxl_q    <= '0;
            bnWeight_q <= '0;
            bnBias_q   <= '0;
            done_q     <= 1'b0;
`ifdef BN_SEQ_PERF_CNT_EN
            stallCnt_q <= '0;
`endif
        end else begin
            bnValid_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        numCh_q    <= cfg_num_ch;
                        pixPerCh_q <= cfg_pix_per_ch;
                        wrPtr_q    <= '0;
                        ch_q       <= '0;
                        pixCnt_q   <= '0;
`ifdef BN_SEQ_PERF_CNT_EN
                        stallCnt_q <= '0;
`endif
                        if ((cfg_num_ch == '0) || (cfg_pix_per_ch == '0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (prm_valid) begin
                        wrPtr_q <= wrPtr_q + CH_W'(1);
                        if (lastLoad) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pxlAccept) begin
                        bnValid_q  <= 1'b1;
                        bnPxl_q    <= pxl_in;
                        bnWeight_q <= weightTab_q[ch_q];
                        bnBias_q   <= biasTab_q[ch_q];
                        if (lastPix) begin
                            pixCnt_q <= '0;
                            ch_q     <= ch_q + CH_W'(1);
                            if (lastCh) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            pixCnt_q <= pixCnt_q + PIX_W'(1);
                        end
                    end
`ifdef BN_SEQ_PERF_CNT_EN
                    else if (stallCnt_q != '1) begin
                        stallCnt_q <= stallCnt_q + 32'd1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign prm_ready       = (state_q == LOAD);
    assign pxl_ready       = (state_q == RUN);
    assign busy            = (state_q == LOAD) || (state_q == RUN);
    assign bn_valid        = bnValid_q;
    assign bn_weight_valid = bnValid_q;
    assign bn_bias_valid   = bnValid_q;
    assign bn_pxl          = bnPxl_q;
    assign bn_weight       = bnWeight_q;
    assign bn_bias         = bnBias_q;
    assign ch_idx          = ch_q;
    assign done            = done_q;
`ifdef BN_SEQ_PERF_CNT_EN
    assign stall_cnt       = stallCnt_q;
`endif

endmodule

// File: tb/tb_cnn_bn_param_sequencer.sv
// Directed bench for cnn_bn_param_sequencer: reset, basic, gapped, boundary, zero-config and
// ignored-event layers, each checked beat by beat against hand-built parameter tables.
module tb_cnn_bn_param_sequencer;

    localparam int DW    = 32;
    localparam int CH_W  = 8;
    localparam int PIX_W = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic            cfgStart;
    logic [CH_W:0]   cfgNumCh;
    logic [PIX_W-1:0] cfgPixPerCh;
    logic            prmValid;
    logic            prmReady;
    logic [DW-1:0]   prmWeight;
    logic [DW-1:0]   prmBias;
    logic            pxlValidIn;
    logic            pxlReady;
    logic [DW-1:0]   pxlIn;
    logic            bnValid;
    logic [DW-1:0]   bnPxl;
    logic            bnWeightValid;
    logic [DW-1:0]   bnWeight;
    logic            bnBiasValid;
    logic [DW-1:0]   bnBias;
    logic [CH_W-1:0] chIdx;
    logic            busy;
    logic            done;
`ifdef BN_SEQ_PERF_CNT_EN
    logic [31:0]     stallCnt;
`endif

    int checkCount = 0;
    int passCount  = 0;

    logic [DW-1:0] wTab [256];
    logic [DW-1:0] bTab [256];

    cnn_bn_param_sequencer dut (
        .clk             (clock),
        .reset           (reset),
        .cfg_start       (cfgStart),
        .cfg_num_ch      (cfgNumCh),
        .cfg_pix_per_ch  (cfgPixPerCh),
        .prm_valid       (prmValid),
        .prm_ready       (prmReady),
        .prm_weight      (prmWeight),
        .prm_bias        (prmBias),
        .pxl_valid_in    (pxlValidIn),
        .pxl_ready       (pxlReady),
        .pxl_in          (pxlIn),
        .bn_valid        (bnValid),
        .bn_pxl          (bnPxl),
        .bn_weight_valid (bnWeightValid),
        .bn_weight       (bnWeight),
        .bn_bias_valid   (bnBiasValid),
        .bn_bias         (bnBias),
        .ch_idx          (chIdx),
        .busy            (busy),
`ifdef BN_SEQ_PERF_CNT_EN
        .stall_cnt       (stallCnt),
`endif
        .done            (done)
    );

    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            passCount++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one full layer: start, load numCh pairs, stream all pixels, check each beat and the done pulse.
    task automatic applyStimulus(input int numCh, input int pixPerCh, input bit gaps, input bit ignored);
        int accepted = 0;
        int stalls   = 0;
        int cyc      = 0;
        int total    = numCh * pixPerCh;
        int expCh;
        bit drive;
        cfgNumCh    = (CH_W+1)'(numCh);
        cfgPixPerCh = PIX_W'(pixPerCh);
        cfgStart    = 1'b1;
        tick();
        cfgStart = 1'b0;
        checkOutput("loadPrmReady", prmReady, 1);
        checkOutput("loadBusy", busy, 1);
        checkOutput("loadPxlReady", pxlReady, 0);
        if (ignored) begin
            cfgNumCh    = 9'd5;
            cfgPixPerCh = 16'd7;
            cfgStart    = 1'b1;
            pxlValidIn  = 1'b1;
            pxlIn       = 32'hBAD0_0000;
            tick();
            cfgStart    = 1'b0;
            pxlValidIn  = 1'b0;
            checkOutput("ignPxlInLoad", bnValid, 0);
            checkOutput("ignStartBusy", busy, 1);
        end
        for (int c = 0; c < numCh; c++) begin
            prmValid  = 1'b1;
            prmWeight = wTab[c];
            prmBias   = bTab[c];
            tick();
        end
        prmValid = 1'b0;
        checkOutput("runPxlReady", pxlReady, 1);
        checkOutput("runPrmReady", prmReady, 0);
        while (accepted < total) begin
            drive      = !gaps || (cyc % 2 == 0);
            pxlValidIn = drive;
            pxlIn      = 32'hA000_0000 + 32'(accepted * 17 + numCh);
            if (ignored) begin
                prmValid  = 1'b1;
                prmWeight = 32'hDEAD_0000 + 32'(cyc);
                prmBias   = 32'hBEEF_0000 + 32'(cyc);
            end
            expCh = accepted / pixPerCh;
            if (drive) checkOutput("chIdx", chIdx, 64'(expCh));
            tick();
            if (drive) begin
                checkOutput("bnValid", bnValid, 1);
                checkOutput("bnWeightValid", bnWeightValid, 1);
                checkOutput("bnBiasValid", bnBiasValid, 1);
                checkOutput("bnPxl", bnPxl, 64'(32'hA000_0000 + 32'(accepted * 17 + numCh)));
                checkOutput("bnWeight", bnWeight, 64'(wTab[expCh]));
                checkOutput("bnBias", bnBias, 64'(bTab[expCh]));
                accepted++;
                checkOutput("doneEarly", done, (accepted == total) ? 1 : 0);
            end else begin
                checkOutput("bnValidGap", bnValid, 0);
                stalls++;
            end
            cyc++;
        end
        pxlValidIn = 1'b0;
        prmValid   = 1'b0;
        checkOutput("doneBusy", busy, 0);
        tick();
        checkOutput("doneAfter", done, 0);
        checkOutput("idleBnValid", bnValid, 0);
        checkOutput("idleBusy", busy, 0);
        checkOutput("idlePrmReady", prmReady, 0);
`ifdef BN_SEQ_PERF_CNT_EN
        checkOutput("stallCnt", stallCnt, 64'(stalls));
        tick();
        checkOutput("stallHold", stallCnt, 64'(stalls));
`endif
    endtask

    task automatic zeroConfig(input int numCh, input int pixPerCh);
        cfgNumCh    = (CH_W+1)'(numCh);
        cfgPixPerCh = PIX_W'(pixPerCh);
        cfgStart    = 1'b1;
        prmValid    = 1'b1;
        pxlValidIn  = 1'b1;
        tick();
        cfgStart = 1'b0;
        checkOutput("zeroDone", done, 1);
        checkOutput("zeroPrmReady", prmReady, 0);
        checkOutput("zeroPxlReady", pxlReady, 0);
        checkOutput("zeroBusy", busy, 0);
        tick();
        checkOutput("zeroDoneOnce", done, 0);
        checkOutput("zeroPrmReady2", prmReady, 0);
        checkOutput("zeroPxlReady2", pxlReady, 0);
        checkOutput("zeroBnValid", bnValid, 0);
        prmValid   = 1'b0;
        pxlValidIn = 1'b0;
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        cfgStart    = 1'b0;
        cfgNumCh    = '0;
        cfgPixPerCh = '0;
        prmValid    = 1'b0;
        prmWeight   = '0;
        prmBias     = '0;
        pxlValidIn  = 1'b0;
        pxlIn       = '0;
        tick();
        tick();
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstBnValid", bnValid, 0);
        checkOutput("rstPrmReady", prmReady, 0);
        checkOutput("rstPxlReady", pxlReady, 0);
        checkOutput("rstChIdx", chIdx, 0);
        checkOutput("rstBnPxl", bnPxl, 0);
        reset = 1'b0;
        tick();

        wTab[0] = 32'h3F80_0000; bTab[0] = 32'h0000_0000;
        wTab[1] = 32'h4000_0000; bTab[1] = 32'h3F80_0000;
        $display("[TB] basic layer");
        applyStimulus(2, 3, 1'b0, 1'b0);
        $display("[TB] gapped layer");
        applyStimulus(2, 3, 1'b1, 1'b0);
        $display("[TB] ignored events");
        applyStimulus(2, 3, 1'b0, 1'b1);

        $display("[TB] reset mid-run");
        cfgNumCh = 9'd2; cfgPixPerCh = 16'd3; cfgStart = 1'b1;
        tick();
        cfgStart = 1'b0;
        for (int c = 0; c < 2; c++) begin
            prmValid = 1'b1; prmWeight = wTab[c]; prmBias = bTab[c];
            tick();
        end
        prmValid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            pxlValidIn = 1'b1; pxlIn = 32'h1234_0000 + 32'(p);
            tick();
        end
        checkOutput("midChIdx", chIdx, 1);
        checkOutput("midBnValid", bnValid, 1);
        reset = 1'b1;
        #1;
        checkOutput("midRstBnValid", bnValid, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstPxlReady", pxlReady, 0);
        checkOutput("midRstChIdx", chIdx, 0);
        checkOutput("midRstBnPxl", bnPxl, 0);
        checkOutput("midRstBnWeight", bnWeight, 0);
        pxlValidIn = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("postRstBusy", busy, 0);
        applyStimulus(2, 3, 1'b0, 1'b0);

        $display("[TB] zero config");
        zeroConfig(0, 3);
        zeroConfig(4, 0);

        $display("[TB] full-depth layer");
        for (int c = 0; c < 256; c++) begin
            wTab[c] = 32'h4000_0000 | 32'(c);
            bTab[c] = 32'hBF00_0000 + 32'(c * 7);
        end
        applyStimulus(256, 1, 1'b0, 1'b0);
        applyStimulus(3, 2, 1'b1, 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
